// File: rtl/kfmmc_sector_buffer.sv
// kfmmc_sector_buffer: one-sector (512 byte) staging buffer between a host and
// the KFMMC drive internal bus. The host fills or drains the sector RAM while
// idle; a request then sends the LBA and access command to the drive and moves
// the sector in the requested direction.
//
// Drive-side handshake: write_block_address_1..4, write_access_command and
// write_data are single-cycle strobes that qualify data_bus in the same cycle.
// They are never asserted together, and data_bus is 0 whenever no strobe is
// active. The drive-event inputs are single-cycle pulses that are acted on
// only in the state that expects them. read_data acknowledges, one cycle
// later, each read_byte_interrupt taken in READ.
module kfmmc_sector_buffer #(
    parameter logic [7:0]  READ_COMMAND  = 8'h80,
    parameter logic [7:0]  WRITE_COMMAND = 8'h81,
    parameter logic [31:0] TIMEOUT       = 32'h00FFFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] host_block_address,
    input  logic        host_read_request,
    input  logic        host_write_request,
    output logic        host_busy,
    output logic        host_done,
    output logic        host_error,
    input  logic        host_rd_en,
    output logic [7:0]  host_rd_data,
    input  logic        host_wr_en,
    input  logic [7:0]  host_wr_data,
    output logic [7:0]  data_bus,
    output logic        write_block_address_1,
    output logic        write_block_address_2,
    output logic        write_block_address_3,
    output logic        write_block_address_4,
    output logic        write_access_command,
    output logic        write_data,
    output logic        read_data,
    input  logic [7:0]  read_data_byte,
    input  logic        drive_busy,
    input  logic        read_byte_interrupt,
    input  logic        read_completion_interrupt,
    input  logic        request_write_data_interrupt,
    input  logic        write_completion_interrupt,
    input  logic        read_interface_error,
    input  logic        read_crc_error,
    input  logic        write_interface_error,
    output logic [3:0]  debug_state
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR1,
        S_ADDR2,
        S_ADDR3,
        S_ADDR4,
        S_CMD,
        S_READ,
        S_W_FETCH,
        S_W_SEND,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] lba;
    logic        is_write;
    logic [8:0]  host_ptr;
    logic [8:0]  drv_ptr;
    logic [9:0]  byte_count;
    logic [31:0] wdog;
    logic        host_rd_q;

    logic [7:0]  ram [0:511];
    logic [7:0]  ram_q;

    logic        accept;
    logic        count_full;
    logic        timeout_hit;
    logic        drive_event;
    logic        host_rd_fire;
    logic        host_wr_fire;
    logic        byte_take;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_wdata;

    assign accept       = (state == S_IDLE) && !drive_busy &&
                          (host_read_request || host_write_request);
    assign count_full   = (byte_count == 10'd512);
    assign timeout_hit  = ((wdog + 32'd1) == TIMEOUT);
    assign drive_event  = read_byte_interrupt || read_completion_interrupt ||
                          request_write_data_interrupt || write_completion_interrupt;
    // The accept cycle clears the host pointer, so host RAM access is held off then.
    assign host_rd_fire = (state == S_IDLE) && host_rd_en && !accept;
    assign host_wr_fire = (state == S_IDLE) && host_wr_en && !accept;
    // A completion in the same cycle as a byte ends the transfer; the byte is not taken.
    assign byte_take    = (state == S_READ) && read_byte_interrupt && !read_completion_interrupt;

    // One RAM port: the host owns the address while idle, the drive pointer otherwise.
    assign ram_addr     = (state == S_IDLE) ? host_ptr : drv_ptr;
    assign ram_wdata    = (state == S_IDLE) ? host_wr_data : read_data_byte;
    assign ram_we       = host_wr_fire || (byte_take && !count_full);

    assign host_rd_data = host_rd_q ? ram_q : 8'h00;
    assign debug_state  = state;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: address/command sequence, then data phase until completion or watchdog.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (accept) state_next = S_ADDR1;
            S_ADDR1:   state_next = S_ADDR2;
            S_ADDR2:   state_next = S_ADDR3;
            S_ADDR3:   state_next = S_ADDR4;
            S_ADDR4:   state_next = S_CMD;
            S_CMD:     state_next = is_write ? S_WRITE : S_READ;
            S_READ: begin
                if (read_completion_interrupt) state_next = S_DONE;
                else if (read_byte_interrupt)  state_next = S_READ;
                else if (timeout_hit)          state_next = S_DONE;
            end
            S_WRITE: begin
                if (write_completion_interrupt)        state_next = S_DONE;
                else if (request_write_data_interrupt) state_next = S_W_FETCH;
                else if (timeout_hit)                  state_next = S_DONE;
            end
            S_W_FETCH: state_next = S_W_SEND;
            S_W_SEND:  state_next = S_WRITE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Drive strobes, data bus and host status decoded from the current state.
    always_comb begin
        write_block_address_1 = 1'b0;
        write_block_address_2 = 1'b0;
        write_block_address_3 = 1'b0;
        write_block_address_4 = 1'b0;
        write_access_command  = 1'b0;
        write_data            = 1'b0;
        data_bus              = 8'h00;
        host_done             = 1'b0;
        host_busy             = (state != S_IDLE) && (state != S_DONE);
        case (state)
            S_ADDR1: begin
                write_block_address_1 = 1'b1;
                data_bus              = lba[7:0];
            end
            S_ADDR2: begin
                write_block_address_2 = 1'b1;
                data_bus              = lba[15:8];
            end
            S_ADDR3: begin
                write_block_address_3 = 1'b1;
                data_bus              = lba[23:16];
            end
            S_ADDR4: begin
                write_block_address_4 = 1'b1;
                data_bus              = lba[31:24];
            end
            S_CMD: begin
                write_access_command  = 1'b1;
                data_bus              = is_write ? WRITE_COMMAND : READ_COMMAND;
            end
            S_W_SEND: begin
                write_data            = 1'b1;
                data_bus              = count_full ? 8'hFF : ram_q;
            end
            S_DONE: begin
                host_done             = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch, pointers, byte count, error flag and read acknowledge.
    always_ff @(posedge clock) begin
        if (reset) begin
            lba        <= 32'h0;
            is_write   <= 1'b0;
            host_ptr   <= 9'd0;
            drv_ptr    <= 9'd0;
            byte_count <= 10'd0;
            host_error <= 1'b0;
            host_rd_q  <= 1'b0;
            read_data  <= 1'b0;
        end else begin
            host_rd_q <= host_rd_fire;
            read_data <= byte_take;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lba        <= host_block_address;
                        is_write   <= !host_read_request;
                        host_error <= 1'b0;
                        host_ptr   <= 9'd0;
                        drv_ptr    <= 9'd0;
                        byte_count <= 10'd0;
                    end else if (host_rd_fire || host_wr_fire) begin
                        // Simultaneous read and write share one pointer step (read sees the old byte).
                        host_ptr <= host_ptr + 9'd1;
                    end
                end
                S_READ: begin
                    if (read_completion_interrupt) begin
                        host_error <= host_error | read_interface_error | read_crc_error | !count_full;
                    end else if (read_byte_interrupt) begin
                        if (count_full) begin
                            host_error <= 1'b1;
                        end else begin
                            byte_count <= byte_count + 10'd1;
                            drv_ptr    <= drv_ptr + 9'd1;
                        end
                    end else if (timeout_hit) begin
                        host_error <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (write_completion_interrupt) begin
                        host_error <= host_error | write_interface_error | !count_full;
                    end else if (!request_write_data_interrupt && timeout_hit) begin
                        host_error <= 1'b1;
                    end
                end
                S_W_SEND: begin
                    drv_ptr <= drv_ptr + 9'd1;
                    if (count_full) begin
                        host_error <= 1'b1;
                    end else begin
                        byte_count <= byte_count + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Watchdog: restarts on any drive event or data-phase entry, counts only in READ/WRITE.
    always_ff @(posedge clock) begin
        if (reset) begin
            wdog <= 32'h0;
        end else if (drive_event ||
                     ((state_next != state) && ((state_next == S_READ) || (state_next == S_WRITE)))) begin
            wdog <= 32'h0;
        end else if ((state == S_READ) || (state == S_WRITE)) begin
            wdog <= wdog + 32'd1;
        end
    end

    // Sector RAM with registered read; contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
        end
        ram_q <= ram[ram_addr];
    end

endmodule

// File: tb/tb_kfmmc_sector_buffer.sv
// tb_kfmmc_sector_buffer: directed sequence of host/drive transactions with
// randomized data and gaps, checked against a byte-array model of the sector.
`timescale 1ns/1ps
module tb_kfmmc_sector_buffer;

    localparam logic [31:0] TB_TIMEOUT = 32'd16;
    localparam logic [7:0]  RD_CMD     = 8'h80;
    localparam logic [7:0]  WR_CMD     = 8'h81;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [31:0] host_block_address;
    logic        host_read_request, host_write_request;
    logic        host_busy, host_done, host_error;
    logic        host_rd_en, host_wr_en;
    logic [7:0]  host_rd_data, host_wr_data;
    logic [7:0]  data_bus;
    logic        write_block_address_1, write_block_address_2;
    logic        write_block_address_3, write_block_address_4;
    logic        write_access_command, write_data, read_data;
    logic [7:0]  read_data_byte;
    logic        drive_busy;
    logic        read_byte_interrupt, read_completion_interrupt;
    logic        request_write_data_interrupt, write_completion_interrupt;
    logic        read_interface_error, read_crc_error, write_interface_error;
    logic [3:0]  debug_state;

    logic [5:0]  strobes;
    assign strobes = {write_block_address_1, write_block_address_2, write_block_address_3,
                      write_block_address_4, write_access_command, write_data};

    kfmmc_sector_buffer #(
        .READ_COMMAND (RD_CMD),
        .WRITE_COMMAND(WR_CMD),
        .TIMEOUT      (TB_TIMEOUT)
    ) dut (
        .clock                       (clock),
        .reset                       (reset),
        .host_block_address          (host_block_address),
        .host_read_request           (host_read_request),
        .host_write_request          (host_write_request),
        .host_busy                   (host_busy),
        .host_done                   (host_done),
        .host_error                  (host_error),
        .host_rd_en                  (host_rd_en),
        .host_rd_data                (host_rd_data),
        .host_wr_en                  (host_wr_en),
        .host_wr_data                (host_wr_data),
        .data_bus                    (data_bus),
        .write_block_address_1       (write_block_address_1),
        .write_block_address_2       (write_block_address_2),
        .write_block_address_3       (write_block_address_3),
        .write_block_address_4       (write_block_address_4),
        .write_access_command        (write_access_command),
        .write_data                  (write_data),
        .read_data                   (read_data),
        .read_data_byte              (read_data_byte),
        .drive_busy                  (drive_busy),
        .read_byte_interrupt         (read_byte_interrupt),
        .read_completion_interrupt   (read_completion_interrupt),
        .request_write_data_interrupt(request_write_data_interrupt),
        .write_completion_interrupt  (write_completion_interrupt),
        .read_interface_error        (read_interface_error),
        .read_crc_error              (read_crc_error),
        .write_interface_error       (write_interface_error),
        .debug_state                 (debug_state)
    );

    // ---------------- model / scoreboard ----------------
    logic [7:0]  model_ram [512];
    int unsigned mptr;
    logic [7:0]  exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobes never overlap and the bus is quiet without a strobe.
    always @(negedge clock) begin
        if (mon_en) begin
            check("strobe_onehot", 32'($countones(strobes) <= 1), 32'd1);
            if (strobes == 6'd0) check("bus_idle", {24'h0, data_bus}, 32'h0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0;
        host_block_address = 32'h0;
        host_read_request = 1'b0;
        host_write_request = 1'b0;
        host_rd_en = 1'b0;
        host_wr_en = 1'b0;
        host_wr_data = 8'h0;
        read_data_byte = 8'h0;
        drive_busy = 1'b0;
        read_byte_interrupt = 1'b0;
        read_completion_interrupt = 1'b0;
        request_write_data_interrupt = 1'b0;
        write_completion_interrupt = 1'b0;
        read_interface_error = 1'b0;
        read_crc_error = 1'b0;
        write_interface_error = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        idle_inputs();
        reset = 1'b1;
        repeat (cycles) step();
        reset = 1'b0;
        mptr = 0;
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_busy"}, {31'h0, host_busy}, 32'h0);
        check({pfx, "_done"}, {31'h0, host_done}, 32'h0);
        check({pfx, "_err"}, {31'h0, host_error}, 32'h0);
        check({pfx, "_strobes"}, {26'h0, strobes}, 32'h0);
        check({pfx, "_bus"}, {24'h0, data_bus}, 32'h0);
        check({pfx, "_rdack"}, {31'h0, read_data}, 32'h0);
        check({pfx, "_rddata"}, {24'h0, host_rd_data}, 32'h0);
    endtask

    task automatic host_write(input logic [7:0] b);
        host_wr_en = 1'b1;
        host_wr_data = b;
        step();
        host_wr_en = 1'b0;
        model_ram[mptr] = b;
        mptr = (mptr + 1) % 512;
    endtask

    task automatic host_read_check(input string tag);
        host_rd_en = 1'b1;
        step();
        host_rd_en = 1'b0;
        check(tag, {24'h0, host_rd_data}, {24'h0, model_ram[mptr]});
        mptr = (mptr + 1) % 512;
    endtask

    // Issues a request and checks the four address strobes and the command.
    // Returns with the command cycle visible.
    task automatic start_request(input logic [31:0] lba, input bit rd, input bit wr);
        logic [7:0] cmd;
        cmd = rd ? RD_CMD : WR_CMD;
        host_block_address = lba;
        host_read_request = rd;
        host_write_request = wr;
        step();
        host_read_request = 1'b0;
        host_write_request = 1'b0;
        host_block_address = $urandom;
        mptr = 0;
        for (int i = 0; i < 5; i++) begin
            check("seq_strobe", {26'h0, strobes}, {26'h0, 6'b100000 >> i});
            check("seq_bus", {24'h0, data_bus}, (i < 4) ? {24'h0, lba[8*i +: 8]} : {24'h0, cmd});
            check("seq_busy", {31'h0, host_busy}, 32'h1);
            if (i < 4) step();
        end
    endtask

    // Feeds n bytes from the drive; mode 0 = i&FF, otherwise random.
    task automatic read_body(input int n, input bit rnd);
        logic [7:0] b;
        step();
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) step();
            b = rnd ? 8'($urandom) : 8'(k);
            read_data_byte = b;
            read_byte_interrupt = 1'b1;
            step();
            read_byte_interrupt = 1'b0;
            check("rd_ack", {31'h0, read_data}, 32'h1);
            if (k < 512) model_ram[k] = b;
        end
    endtask

    task automatic read_finish(input bit rie, input bit crc, input bit exp_err);
        repeat ($urandom_range(0, 3)) step();
        read_interface_error = rie;
        read_crc_error = crc;
        read_completion_interrupt = 1'b1;
        step();
        read_completion_interrupt = 1'b0;
        read_interface_error = 1'b0;
        read_crc_error = 1'b0;
        check("rd_done", {31'h0, host_done}, 32'h1);
        check("rd_done_busy", {31'h0, host_busy}, 32'h0);
        check("rd_err", {31'h0, host_error}, {31'h0, exp_err});
        step();
        check("rd_done_pulse", {31'h0, host_done}, 32'h0);
        check("rd_err_hold", {31'h0, host_error}, {31'h0, exp_err});
    endtask

    // Serves n write-data requests; each byte must appear two cycles after its request.
    task automatic write_body(input int n);
        logic [7:0] e;
        for (int k = 0; k < n; k++) exp_q.push_back((k < 512) ? model_ram[k] : 8'hFF);
        step();
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) step();
            request_write_data_interrupt = 1'b1;
            step();
            request_write_data_interrupt = 1'b0;
            check("wr_early", {31'h0, write_data}, 32'h0);
            step();
            check("wr_strobe", {31'h0, write_data}, 32'h1);
            e = exp_q.pop_front();
            check("wr_byte", {24'h0, data_bus}, {24'h0, e});
            step();
        end
    endtask

    task automatic write_finish(input bit wie, input bit exp_err);
        write_interface_error = wie;
        write_completion_interrupt = 1'b1;
        step();
        write_completion_interrupt = 1'b0;
        write_interface_error = 1'b0;
        check("wr_done", {31'h0, host_done}, 32'h1);
        check("wr_err", {31'h0, host_error}, {31'h0, exp_err});
        step();
        check("wr_done_pulse", {31'h0, host_done}, 32'h0);
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < 512; i++) host_read_check(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cnt;
        idle_inputs();
        do_reset(3);
        mon_en = 1'b1;
        check_idle("rst");

        // RAM survives reset; pointer returns to 0.
        host_write(8'hA5);
        host_write(8'h3C);
        do_reset(1);
        host_read_check("rst_ram0");
        host_read_check("rst_ram1");

        // Sector read with incrementing data, then host readback.
        start_request(32'h12345678, 1'b1, 1'b0);
        read_body(512, 1'b0);
        read_finish(1'b0, 1'b0, 1'b0);
        readback("rd_back");

        // Sector write of host-filled 8'hFF-i.
        for (int i = 0; i < 512; i++) host_write(8'(8'hFF - i));
        start_request(32'd5, 1'b0, 1'b1);
        write_body(512);
        write_finish(1'b0, 1'b0);

        // Read error cases: CRC flag, interface flag, short and long sectors.
        start_request($urandom, 1'b1, 1'b0);
        read_body(512, 1'b1);
        read_finish(1'b0, 1'b1, 1'b1);
        start_request($urandom, 1'b1, 1'b0);
        read_body(512, 1'b1);
        read_finish(1'b1, 1'b0, 1'b1);
        start_request($urandom, 1'b1, 1'b0);
        read_body(511, 1'b1);
        read_finish(1'b0, 1'b0, 1'b1);
        start_request($urandom, 1'b1, 1'b0);
        read_body(513, 1'b1);
        read_finish(1'b0, 1'b0, 1'b1);
        readback("rd_long_back");

        // Write with one request too many: filler byte and error.
        start_request($urandom, 1'b0, 1'b1);
        write_body(513);
        write_finish(1'b0, 1'b1);

        // Watchdog: no drive events after the command.
        start_request($urandom, 1'b1, 1'b0);
        cnt = 0;
        while (!host_done && cnt < 40) begin
            step();
            cnt++;
        end
        check("to_latency", 32'(cnt), TB_TIMEOUT + 32'd1);
        check("to_err", {31'h0, host_error}, 32'h1);
        step();

        // Reset in the middle of a read, then a clean read.
        start_request($urandom, 1'b1, 1'b0);
        read_body(100, 1'b1);
        do_reset(1);
        check_idle("midrst");
        start_request($urandom, 1'b1, 1'b0);
        read_body(512, 1'b1);
        read_finish(1'b0, 1'b0, 1'b0);
        readback("midrst_back");

        // Drive busy holds off a request; simultaneous requests resolve to read.
        drive_busy = 1'b1;
        host_read_request = 1'b1;
        host_write_request = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("dbusy_hold", {31'h0, host_busy}, 32'h0);
        end
        drive_busy = 1'b0;
        start_request($urandom, 1'b1, 1'b1);
        do_reset(1);
        check_idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Run-length guard.
    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
